// File: rtl/reset_seq_pkg.sv
// Shared encodings and width helper for the staged reset sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    CAUSE_POR  = 2'd0,
    CAUSE_SW   = 2'd1,
    CAUSE_BTN  = 2'd2,
    CAUSE_WDOG = 2'd3
  } cause_e;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_e;

  // Bits needed to hold values 0..value-1; never less than 1.
  function automatic int unsigned clog2w(input int unsigned value);
    int unsigned w;
    w = 1;
    while ((64'(1) << w) < 64'(value)) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Front-panel button synchronizer; RESET_SEQ_DEBOUNCE_EN adds a stable-low debounce filter.
module btn_conditioner
  import reset_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic req_btn
);

  logic sync1;
  logic sync2;

  // Synchronizer resets to the released (high) level so no request appears at power-up.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end

`ifdef RESET_SEQ_DEBOUNCE_EN
  localparam int unsigned DbW = clog2w(DEBOUNCE_CYCLES + 1);
  localparam logic [DbW-1:0] DbMax = DbW'(DEBOUNCE_CYCLES);

  logic [DbW-1:0] db_cnt;

  always_ff @(posedge clk) begin
    if (reset || sync2) begin
      db_cnt <= '0;
    end else if (db_cnt != DbMax) begin
      db_cnt <= db_cnt + DbW'(1);
    end
  end

  assign req_btn = ~sync2 & (db_cnt == DbMax);
`else
  assign req_btn = ~sync2;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    assert (DEBOUNCE_CYCLES >= 1)
      else $error("btn_conditioner: DEBOUNCE_CYCLES must be at least 1");
  end
`endif

endmodule

// File: rtl/reset_seq.sv
// Staged board reset sequencer: hold all domains, then release them in order.
// Button debounce is enabled by defining RESET_SEQ_DEBOUNCE_EN.
module reset_seq
  import reset_seq_pkg::*;
#(
  parameter int unsigned NUM_STAGES      = 3,
  parameter int unsigned HOLD_CYCLES     = 64,
  parameter int unsigned STAGE_GAP       = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  btn_n,
  input  logic                  sw_req,
  input  logic                  wdog_expire,
  output logic [NUM_STAGES-1:0] stage_rst_n,
  output logic                  all_released,
  output logic [1:0]            cause
);

  localparam int unsigned HoldW = clog2w(HOLD_CYCLES + 1);
  localparam int unsigned GapW  = clog2w(STAGE_GAP + 1);
  localparam logic [HoldW-1:0] HoldLoad = HoldW'(HOLD_CYCLES);
  localparam logic [GapW-1:0]  GapLoad  = GapW'(STAGE_GAP);

  logic                  req_btn;
  logic                  req;
  state_e                state;
  logic [HoldW-1:0]      hold_cnt;
  logic [GapW-1:0]       gap_cnt;
  logic [NUM_STAGES-1:0] next_stages;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_conditioner (
    .clk    (clk),
    .reset  (reset),
    .btn_n  (btn_n),
    .req_btn(req_btn)
  );

  assign req = req_btn | sw_req | wdog_expire;

  // Stages release as a thermometer code growing from bit 0.
  assign next_stages = (stage_rst_n << 1) | NUM_STAGES'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_HOLD;
      hold_cnt     <= HoldLoad;
      gap_cnt      <= GapLoad;
      stage_rst_n  <= '0;
      all_released <= 1'b0;
      cause        <= CAUSE_POR;
    end else if (req) begin
      state        <= ST_HOLD;
      hold_cnt     <= HoldLoad;
      gap_cnt      <= GapLoad;
      stage_rst_n  <= '0;
      all_released <= 1'b0;
      cause        <= wdog_expire ? CAUSE_WDOG :
                      req_btn     ? CAUSE_BTN  : CAUSE_SW;
    end else begin
      unique case (state)
        ST_HOLD: begin
          if (hold_cnt <= HoldW'(1)) begin
            stage_rst_n  <= next_stages;
            all_released <= &next_stages;
            gap_cnt      <= GapLoad;
            state        <= (&next_stages) ? ST_RUN : ST_RELEASE;
          end else begin
            hold_cnt <= hold_cnt - HoldW'(1);
          end
        end
        ST_RELEASE: begin
          if (gap_cnt <= GapW'(1)) begin
            stage_rst_n  <= next_stages;
            all_released <= &next_stages;
            gap_cnt      <= GapLoad;
            state        <= (&next_stages) ? ST_RUN : ST_RELEASE;
          end else begin
            gap_cnt <= gap_cnt - GapW'(1);
          end
        end
        ST_RUN: begin
          state <= ST_RUN;
        end
        default: begin
          state    <= ST_HOLD;
          hold_cnt <= HoldLoad;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    assert (HOLD_CYCLES >= 1 && STAGE_GAP >= 1 && NUM_STAGES >= 1)
      else $error("reset_seq: HOLD_CYCLES, STAGE_GAP and NUM_STAGES must be at least 1");
  end
`endif

endmodule
